lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit; consumes the decoder's LSU controls (size, sign-ext, write-enable) and the ALU address.
//  Runs one data-memory transaction per request over a req/ack bus and stalls the pipeline while it is in flight.
//  Aligns loaded data to the register and sign/zero-extends it; byte-lane-replicates stores and generates byte enables.
//  Sits between execute and writeback; o_rdata feeds the writeback LOAD select.
// PARAMETERS
//  TIMEOUT_W  5  width of ack-timeout counter; abort after 2**TIMEOUT_W-1 bus cycles without ack
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_rst_n        in   1   reset, asynchronous, active-low
//  i_req          in   1   memory op valid (held by pipeline while o_stall=1)
//  i_we           in   1   1=store, 0=load
//  i_size         in   2   00=byte 01=half 10=word 11=illegal
//  i_sign_ext     in   1   1=sign-extend load, 0=zero-extend
//  i_addr         in   32  byte address
//  i_wdata        in   32  store data (low bits significant)
//  o_stall        out  1   hold pipeline
//  o_done         out  1   one-cycle completion pulse
//  o_err          out  1   valid with o_done: misaligned, illegal size or timeout
//  o_rdata        out  32  extended load result, valid with o_done on loads
//  o_mem_req      out  1   bus request
//  o_mem_we       out  1   bus write
//  o_mem_addr     out  32  word address {addr[31:2],2'b00}
//  o_mem_be       out  4   byte enables
//  o_mem_wdata    out  32  lane-replicated store data
//  i_mem_ack      in   1   bus ack; for reads i_mem_rdata valid same cycle
//  i_mem_rdata    in   32  bus read data (full word)
// BEHAVIOUR
//  Reset: state=IDLE; o_mem_req, o_mem_we, o_done, o_err, o_mem_be = 0; o_rdata, o_mem_addr, o_mem_wdata = 0.
//  FSM: IDLE, BUS, RESP.
//  IDLE: on i_req, register we, size, sign, addr[1:0], mem_addr, be, wdata.
//   If aligned and legal -> BUS. Otherwise -> RESP with err=1, no bus access.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
//  BUS: o_mem_req=1 with registered addr/be/we/wdata held stable until ack; timeout counter increments each cycle.
//   On i_mem_ack -> RESP; for loads capture the extended lane. Ack in the first BUS cycle is legal.
//   On counter saturation without ack -> RESP with err=1, o_mem_req drops.
//  RESP: o_done=1 for exactly one cycle, o_stall=0 -> IDLE. i_req seen in RESP is the same op and is NOT re-accepted.
//  o_stall = (IDLE & i_req) | BUS, combinational.
//   Minimum latency: 2 stall cycles + RESP (ack in first BUS cycle).
//  Byte enables: byte 4'b0001<<a; half 4'b0011<<a; word 4'b1111 (a=addr[1:0]).
//  Store wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//  Load: w = i_mem_rdata >> (8*a); byte -> ext(w[7:0]); half -> ext(w[15:0]); word -> w.
//   ext = sign when i_sign_ext=1, else zero.
//  Stores leave o_rdata unchanged. On o_err, o_rdata=0 and the CPU raises the exception.
//  Reset mid-BUS: o_mem_req deasserts asynchronously; the transaction is abandoned with no o_done.
// STRUCTURE
//  Shared header lsu.vh: LSU_SIZE_B/H/W (shared with the decoder's o_lsu_size encoding) and LSU_ST_IDLE/BUS/RESP.
//  Sub-module lsu_align (combinational): be/wdata lane generation and load shift/extend.
//   The FSM, timeout counter and registers live in lsu.
// TESTING
//  LB, sign=1, addr=0x103, rdata=0x80FFFFFF -> be=1000, mem_addr=0x100, o_rdata=0xFFFFFF80.
//  LHU addr=0x102, rdata=0xBEEF1234 -> o_rdata=0x0000BEEF.
//  SB addr=0x101, wdata=0x000000A5 -> be=0010, mem_wdata=0xA5A5A5A5, o_done one cycle after ack.
//  SW addr=0x102 -> no o_mem_req; o_done=1, o_err=1; o_stall high exactly 1 cycle.
//  LW with ack withheld -> o_err after 31 BUS cycles (TIMEOUT_W=5); o_mem_req low afterwards.
//  Ack delayed 3 cycles: o_mem_addr/be stable throughout.
//  Back-to-back ops: second i_req accepted only after RESP.
//  i_rst_n low during BUS -> o_mem_req=0 immediately, state IDLE, no o_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU encodings (size codes match the decoder's lsu_size field), FSM states and bus payload.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_X = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'b00,
        LSU_ST_BUS  = 2'b01,
        LSU_ST_RESP = 2'b10
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_bus_t;

    // Legal size and natural alignment for the given byte lane.
    function automatic logic lsu_legal(input lsu_size_e size, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (size)
            LSU_SIZE_B: ok = 1'b1;
            LSU_SIZE_H: ok = ~lane[0];
            LSU_SIZE_W: ok = (lane == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replication and load shift / extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      i_st_lane,
    input  lsu_size_e       i_st_size,
    input  logic [XLEN-1:0] i_st_data,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    input  logic [1:0]      i_ld_lane,
    input  lsu_size_e       i_ld_size,
    input  logic            i_ld_sign,
    input  logic [XLEN-1:0] i_ld_data,
    output logic [XLEN-1:0] o_rdata_c
);

    logic [XLEN-1:0] w_shift;

    always_comb begin
        o_be_c    = '0;
        o_wdata_c = i_st_data;
        case (i_st_size)
            LSU_SIZE_B: begin
                o_be_c    = BE_W'(4'b0001 << i_st_lane);
                o_wdata_c = {4{i_st_data[7:0]}};
            end
            LSU_SIZE_H: begin
                o_be_c    = BE_W'(4'b0011 << i_st_lane);
                o_wdata_c = {2{i_st_data[15:0]}};
            end
            LSU_SIZE_W: o_be_c = 4'b1111;
            default:    o_be_c = '0;
        endcase
    end

    assign w_shift = i_ld_data >> {i_ld_lane, 3'b000};

    always_comb begin
        o_rdata_c = w_shift;
        case (i_ld_size)
            LSU_SIZE_B: o_rdata_c = {{24{i_ld_sign & w_shift[7]}}, w_shift[7:0]};
            LSU_SIZE_H: o_rdata_c = {{16{i_ld_sign & w_shift[15]}}, w_shift[15:0]};
            default:    o_rdata_c = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per request, pipeline stall while in flight.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [1:0]      i_size,
    input  logic            i_sign_ext,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_done,
    output logic            o_err,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [BE_W-1:0] o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    // Last BUS cycle index before abort: 2**TIMEOUT_W-1 cycles in total.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    lsu_state_e           r_state, w_next_state;
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt;
    lsu_size_e            r_size;
    logic                 r_sign;
    logic [1:0]           r_lane;
    lsu_bus_t             r_bus;
    logic                 r_mem_req, r_done, r_err;
    logic [XLEN-1:0]      r_rdata;

    lsu_size_e            w_size;
    logic [BE_W-1:0]      w_be;
    logic [XLEN-1:0]      w_wdata, w_ld_data;
    logic                 w_mem_req, w_done, w_err, w_accept, w_capture;

    assign w_size = lsu_size_e'(i_size);

    lsu_align u_align (
        .i_st_lane (i_addr[1:0]),
        .i_st_size (w_size),
        .i_st_data (i_wdata),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata),
        .i_ld_lane (r_lane),
        .i_ld_size (r_size),
        .i_ld_sign (r_sign),
        .i_ld_data (i_mem_rdata),
        .o_rdata_c (w_ld_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= LSU_ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt        = '0;
        w_mem_req    = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            LSU_ST_IDLE: begin
                if (i_req) begin
                    w_accept = 1'b1;
                    if (lsu_legal(w_size, i_addr[1:0])) begin
                        w_next_state = LSU_ST_BUS;
                        w_mem_req    = 1'b1;
                    end else begin
                        w_next_state = LSU_ST_RESP;
                        w_done       = 1'b1;
                        w_err        = 1'b1;
                    end
                end
            end
            LSU_ST_BUS: begin
                w_cnt = r_cnt + TIMEOUT_W'(1);
                if (i_mem_ack) begin
                    w_next_state = LSU_ST_RESP;
                    w_done       = 1'b1;
                    w_capture    = ~r_bus.we;
                end else if (r_cnt == TMO_LAST) begin
                    w_next_state = LSU_ST_RESP;
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                end else begin
                    w_mem_req = 1'b1;
                end
            end
            // RESP always returns to IDLE: a still-high i_req is the op just completed.
            default: w_next_state = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_size    <= LSU_SIZE_B;
            r_sign    <= 1'b0;
            r_lane    <= '0;
            r_bus     <= '0;
            r_mem_req <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_cnt     <= w_cnt;
            r_mem_req <= w_mem_req;
            r_done    <= w_done;
            r_err     <= w_err;
            if (w_accept) begin
                r_size       <= w_size;
                r_sign       <= i_sign_ext;
                r_lane       <= i_addr[1:0];
                r_bus.we     <= i_we;
                r_bus.be     <= w_be;
                r_bus.addr   <= {i_addr[XLEN-1:2], 2'b00};
                r_bus.wdata  <= w_wdata;
            end
            if (w_capture)          r_rdata <= w_ld_data;
            else if (w_done && w_err) r_rdata <= '0;
        end
    end

    assign o_stall     = ((r_state == LSU_ST_IDLE) && i_req) || (r_state == LSU_ST_BUS);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_bus.we;
    assign o_mem_addr  = r_bus.addr;
    assign o_mem_be    = r_bus.be;
    assign o_mem_wdata = r_bus.wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: bus responder with programmable ack delay, hand-computed expectations.
module tb_lsu;

    logic        i_clk, i_rst_n;
    logic        i_req, i_we, i_sign_ext, i_mem_ack;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata, i_mem_rdata;
    logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the most recent run_op.
    int          ob_stall, ob_req;
    logic        ob_done, ob_err, ob_stable, ob_we, ob_resp_stall, ob_after_done, ob_after_req;
    logic [31:0] ob_rdata, ob_addr, ob_wdata;
    logic [3:0]  ob_be;

    lsu #(.TIMEOUT_W(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
        .i_sign_ext(i_sign_ext), .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall),
        .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, answer the bus after ack_dly request cycles (negative = never), observe to o_done.
    task automatic run_op(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_dly);
        @(negedge i_clk);
        i_req = 1'b1; i_we = we; i_size = size; i_sign_ext = sign;
        i_addr = addr; i_wdata = wdata; i_mem_ack = 1'b0;
        ob_stall = 0; ob_req = 0; ob_done = 1'b0; ob_err = 1'b0; ob_stable = 1'b1;
        ob_rdata = '0; ob_addr = '0; ob_wdata = '0; ob_be = '0; ob_we = 1'b0;
        ob_resp_stall = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (o_done) begin
                ob_done = 1'b1; ob_err = o_err; ob_rdata = o_rdata; ob_resp_stall = o_stall;
                break;
            end
            if (o_stall) ob_stall++;
            if (o_mem_req) begin
                if (ob_req == 0) begin
                    ob_addr = o_mem_addr; ob_be = o_mem_be; ob_wdata = o_mem_wdata; ob_we = o_mem_we;
                end else if (o_mem_addr !== ob_addr || o_mem_be !== ob_be || o_mem_wdata !== ob_wdata) begin
                    ob_stable = 1'b0;
                end
                if (ack_dly >= 0 && ob_req >= ack_dly) begin
                    i_mem_ack = 1'b1; i_mem_rdata = rdata;
                end
                ob_req++;
            end
            @(negedge i_clk);
            i_mem_ack = 1'b0; i_mem_rdata = 32'h5A5A_5A5A;
        end
        // i_req stays high through the RESP cycle; it must not start a second transaction.
        @(negedge i_clk);
        i_req = 1'b0;
        #1;
        ob_after_done = o_done;
        ob_after_req  = o_mem_req;
    endtask

    task automatic chk_common(input string tag, input logic err, input int stall, input int nreq);
        chk({tag, "_done"},       32'(ob_done), 32'(1));
        chk({tag, "_err"},        32'(ob_err), 32'(err));
        chk({tag, "_stall_cyc"},  32'(ob_stall), 32'(stall));
        chk({tag, "_req_cyc"},    32'(ob_req), 32'(nreq));
        chk({tag, "_resp_stall"}, 32'(ob_resp_stall), 32'(0));
        chk({tag, "_done_pulse"}, 32'(ob_after_done), 32'(0));
        chk({tag, "_no_reaccept"}, 32'(ob_after_req), 32'(0));
    endtask

    initial begin
        logic bad;
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
        i_addr = '0; i_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        #12;
        chk("rst_mem_req", 32'(o_mem_req), 32'(0));
        chk("rst_done",    32'(o_done), 32'(0));
        chk("rst_err",     32'(o_err), 32'(0));
        chk("rst_be",      32'(o_mem_be), 32'(0));
        chk("rst_rdata",   o_rdata, 32'h0);
        chk("rst_addr",    o_mem_addr, 32'h0);
        chk("rst_wdata",   o_mem_wdata, 32'h0);
        chk("rst_stall",   32'(o_stall), 32'(0));
        @(negedge i_clk); i_rst_n = 1'b1;

        // LB sign-extended, top lane
        run_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0);
        chk_common("lb", 1'b0, 2, 1);
        chk("lb_be", 32'(ob_be), 32'(4'b1000));
        chk("lb_addr", ob_addr, 32'h0000_0100);
        chk("lb_we", 32'(ob_we), 32'(0));
        chk("lb_rdata", ob_rdata, 32'hFFFF_FF80);

        // LHU upper half, ack one cycle late
        run_op(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 1);
        chk_common("lhu", 1'b0, 3, 2);
        chk("lhu_be", 32'(ob_be), 32'(4'b1100));
        chk("lhu_rdata", ob_rdata, 32'h0000_BEEF);

        // SB lane 1; o_rdata must keep the previous load value
        run_op(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0);
        chk_common("sb", 1'b0, 2, 1);
        chk("sb_be", 32'(ob_be), 32'(4'b0010));
        chk("sb_wdata", ob_wdata, 32'hA5A5_A5A5);
        chk("sb_we", 32'(ob_we), 32'(1));
        chk("sb_rdata_kept", ob_rdata, 32'h0000_BEEF);

        // SH lane 2
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0);
        chk_common("sh", 1'b0, 2, 1);
        chk("sh_be", 32'(ob_be), 32'(4'b1100));
        chk("sh_wdata", ob_wdata, 32'hABCD_ABCD);

        // Misaligned SW: no bus, immediate error, rdata cleared
        run_op(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_2222, 32'h0, 0);
        chk_common("sw_mis", 1'b1, 1, 0);
        chk("sw_mis_rdata", ob_rdata, 32'h0);

        // LH sign-extended, lane 0
        run_op(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h1234_8001, 0);
        chk_common("lh", 1'b0, 2, 1);
        chk("lh_rdata", ob_rdata, 32'hFFFF_8001);

        // LW with ack delayed 3 cycles: bus fields stable
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
        chk_common("lw_dly", 1'b0, 5, 4);
        chk("lw_dly_stable", 32'(ob_stable), 32'(1));
        chk("lw_dly_addr", ob_addr, 32'h0000_0104);
        chk("lw_dly_be", 32'(ob_be), 32'(4'b1111));
        chk("lw_dly_rdata", ob_rdata, 32'hDEAD_BEEF);

        // Illegal size
        run_op(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
        chk_common("ill", 1'b1, 1, 0);

        // LW timeout: 31 request cycles, then error
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h0, -1);
        chk_common("tmo", 1'b1, 32, 31);
        chk("tmo_rdata", ob_rdata, 32'h0);

        // LBU lane 2
        run_op(1'b0, 2'b00, 1'b0, 32'h0000_0302, 32'h0, 32'h00C3_0000, 2);
        chk_common("lbu", 1'b0, 4, 3);
        chk("lbu_be", 32'(ob_be), 32'(4'b0100));
        chk("lbu_rdata", ob_rdata, 32'h0000_00C3);

        // Reset while in BUS: request drops at once, no completion
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = 32'h0000_0400;
        @(negedge i_clk);
        @(negedge i_clk);
        #1 chk("rstbus_req_before", 32'(o_mem_req), 32'(1));
        #2 i_rst_n = 1'b0; i_req = 1'b0;
        #1;
        chk("rstbus_req_async", 32'(o_mem_req), 32'(0));
        chk("rstbus_done", 32'(o_done), 32'(0));
        @(negedge i_clk); i_rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk); #1;
            if (o_done || o_mem_req || o_stall) bad = 1'b1;
        end
        chk("rstbus_quiet", 32'(bad), 32'(0));

        // Unit is usable again after the abandoned transaction
        run_op(1'b0, 2'b00, 1'b1, 32'h0000_0501, 32'h0, 32'h0000_7F00, 0);
        chk_common("post_rst", 1'b0, 2, 1);
        chk("post_rst_rdata", ob_rdata, 32'h0000_007F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
